// File: rtl/am2907_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : am2907_bus_ctl
// Purpose  : Round-robin arbiter and cycle sequencer for one am2907
//            transceiver slice sitting between a local bus and a shared
//            open-collector system bus. Runs one complete write or read
//            cycle per grant and checks read parity.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            req_i, rd_i     - per-master request level and direction
//            odd_i, pbus_i   - transceiver parity vs. system bus parity
//            perr_clr_i      - clears the sticky parity error flag
//            gnt_o, ack_o    - one-hot grant, one-cycle completion pulse
//            drcp_o, be_n_o, rle_n_o, oe_n_o - transceiver controls
//            busy_o, perr_o, perr_sticky_o   - status
// Revision : 1.0 - initial release
// ============================================================================
module am2907_bus_ctl #(
  parameter int NREQ = 4,
  parameter int TDRV = 2,
  parameter int TSET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] rd_i,
  input  logic            odd_i,
  input  logic            pbus_i,
  input  logic            perr_clr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] ack_o,
  output logic            drcp_o,
  output logic            be_n_o,
  output logic            rle_n_o,
  output logic            oe_n_o,
  output logic            busy_o,
  output logic            perr_o,
  output logic            perr_sticky_o
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (TDRV > TSET) ? TDRV : TSET;
  localparam int CW   = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] DRV_LOAD = CW'(TDRV - 1);
  localparam logic [CW-1:0] SET_LOAD = CW'(TSET - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRIVE = 3'd2,
    S_RCV   = 3'd3,
    S_CAPT  = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            drcp_q;
  logic            be_n_q;
  logic            rle_n_q;
  logic            oe_n_q;
  logic            busy_q;
  logic            perr_q;
  logic            perr_sticky_q;

  // Round-robin winner: first requester strictly after the last winner.
  logic [PW-1:0]   ptr_d;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_idx;
  logic            w_found;

  always_comb begin
    ptr_d   = ptr_q;
    w_sum   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        ptr_d   = w_idx;
      end
    end
  end

  // Every output is registered and set on the edge that enters the state
  // it belongs to, so outputs line up with the state cycle by cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      drcp_q  <= 1'b0;
      be_n_q  <= 1'b1;
      rle_n_q <= 1'b1;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            ptr_q  <= ptr_d;
            gnt_q  <= NREQ'(1) << ptr_d;
            busy_q <= 1'b1;
            // Direction is taken only here; later rd changes are ignored.
            if (rd_i[ptr_d]) begin
              state_q <= S_RCV;
              rle_n_q <= 1'b0;
              cnt_q   <= SET_LOAD;
            end else begin
              state_q <= S_LOAD;
              drcp_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // drcp drops on the same edge be_ goes low: never both active.
          drcp_q  <= 1'b0;
          be_n_q  <= 1'b0;
          cnt_q   <= DRV_LOAD;
          state_q <= S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt_q == '0) begin
            be_n_q  <= 1'b1;
            ack_q   <= gnt_q;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RCV: begin
          if (cnt_q == '0) begin
            rle_n_q <= 1'b1;
            oe_n_q  <= 1'b0;
            state_q <= S_CAPT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CAPT: begin
          perr_q  <= odd_i ^ pbus_i;
          ack_q   <= gnt_q;
          state_q <= S_ACK;
        end
        S_ACK: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          oe_n_q  <= 1'b1;
          rle_n_q <= 1'b1;
          be_n_q  <= 1'b1;
          perr_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          ack_q   <= '0;
          drcp_q  <= 1'b0;
          be_n_q  <= 1'b1;
          rle_n_q <= 1'b1;
          oe_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          perr_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag rises together with perr; a set beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_sticky_q <= 1'b0;
    end else if ((state_q == S_CAPT) && (odd_i ^ pbus_i)) begin
      perr_sticky_q <= 1'b1;
    end else if (perr_clr_i) begin
      perr_sticky_q <= 1'b0;
    end
  end

  assign gnt_o         = gnt_q;
  assign ack_o         = ack_q;
  assign drcp_o        = drcp_q;
  assign be_n_o        = be_n_q;
  assign rle_n_o       = rle_n_q;
  assign oe_n_o        = oe_n_q;
  assign busy_o        = busy_q;
  assign perr_o        = perr_q;
  assign perr_sticky_o = perr_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_am2907_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2907_bus_ctl
// Purpose  : Self-checking bench for am2907_bus_ctl. A transaction-level
//            model predicts the winner from the round-robin rule and the
//            per-cycle control waveform from each cycle's offset after the
//            grant decision.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am2907_bus_ctl;

  localparam int NREQ = 4;
  localparam int TDRV = 2;
  localparam int TSET = 1;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] rd_i;
  logic            odd_i;
  logic            pbus_i;
  logic            perr_clr_i;
  logic [NREQ-1:0] gnt_o;
  logic [NREQ-1:0] ack_o;
  logic            drcp_o;
  logic            be_n_o;
  logic            rle_n_o;
  logic            oe_n_o;
  logic            busy_o;
  logic            perr_o;
  logic            perr_sticky_o;

  am2907_bus_ctl #(.NREQ(NREQ), .TDRV(TDRV), .TSET(TSET)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .rd_i          (rd_i),
    .odd_i         (odd_i),
    .pbus_i        (pbus_i),
    .perr_clr_i    (perr_clr_i),
    .gnt_o         (gnt_o),
    .ack_o         (ack_o),
    .drcp_o        (drcp_o),
    .be_n_o        (be_n_o),
    .rle_n_o       (rle_n_o),
    .oe_n_o        (oe_n_o),
    .busy_o        (busy_o),
    .perr_o        (perr_o),
    .perr_sticky_o (perr_sticky_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int ptr_m;       // index of the last granted master
  bit sticky_m;    // expected perr_sticky
  bit rand_clr;    // randomise perr_clr each cycle when set
  bit force_clr;   // hold perr_clr high when set

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string ph, input logic [NREQ-1:0] g, input logic [NREQ-1:0] a,
                         input bit dr, input bit be, input bit rl, input bit oe,
                         input bit bz, input bit pe);
    chk({ph, ".gnt"},  32'(gnt_o),  32'(g));
    chk({ph, ".ack"},  32'(ack_o),  32'(a));
    chk({ph, ".drcp"}, 32'(drcp_o), 32'(dr));
    chk({ph, ".be_"},  32'(be_n_o), 32'(be));
    chk({ph, ".rle_"}, 32'(rle_n_o), 32'(rl));
    chk({ph, ".oe_"},  32'(oe_n_o), 32'(oe));
    chk({ph, ".busy"}, 32'(busy_o), 32'(bz));
    chk({ph, ".perr"}, 32'(perr_o), 32'(pe));
    chk({ph, ".sticky"}, 32'(perr_sticky_o), 32'(sticky_m));
    chk({ph, ".be_rle_excl"}, 32'(!be_n_o && !rle_n_o), 32'd0);
    chk({ph, ".drcp_be_excl"}, 32'(drcp_o && !be_n_o), 32'd0);
  endtask

  // Advance one clock; 'set' says a parity error is captured at this edge.
  task automatic tick(input bit set);
    sticky_m = set || (sticky_m && !perr_clr_i);
    @(posedge clk);
    #1;
    perr_clr_i = force_clr ? 1'b1 : (rand_clr ? ($urandom_range(0, 3) == 0) : 1'b0);
  endtask

  // Entered #1 into an IDLE cycle; leaves #1 into the following IDLE cycle.
  task automatic do_xfer(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rdv,
                         input bit od, input bit pb, input bit drop);
    int w;
    int len;
    bit isrd;
    logic [1:0] wi;
    logic [NREQ-1:0] g;
    bit dr, be, rl, oe, pe;
    req_i  = rq;
    rd_i   = rdv;
    odd_i  = od;
    pbus_i = pb;
    chk_all("idle", '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    if (rq == '0) begin
      tick(1'b0);
      return;
    end
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (w < 0 && rq[idx]) w = idx;
    end
    ptr_m = w;
    wi    = 2'(w);
    isrd  = rdv[wi];
    len   = isrd ? (TSET + 2) : (TDRV + 2);
    g     = NREQ'(1) << wi;
    tick(1'b0);
    for (int off = 1; off <= len; off++) begin
      if (isrd) begin
        dr = 1'b0;
        be = 1'b1;
        rl = (off <= TSET) ? 1'b0 : 1'b1;
        oe = (off >= TSET + 1) ? 1'b0 : 1'b1;
        pe = (off == len) ? (od != pb) : 1'b0;
      end else begin
        dr = (off == 1);
        be = (off >= 2 && off <= TDRV + 1) ? 1'b0 : 1'b1;
        rl = 1'b1;
        oe = 1'b1;
        pe = 1'b0;
      end
      chk_all(isrd ? "rd" : "wr", g, (off == len) ? g : '0, dr, be, rl, oe, 1'b1, pe);
      // Direction changes after the grant must be ignored.
      rd_i = NREQ'($urandom);
      if (drop && off == 1) req_i[wi] = 1'b0;
      tick(isrd && (off == TSET + 1) && (od != pb));
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    ptr_m      = NREQ - 1;
    sticky_m   = 1'b0;
    rand_clr   = 1'b0;
    force_clr  = 1'b0;
    rst        = 1'b1;
    req_i      = '0;
    rd_i       = '0;
    odd_i      = 1'b0;
    pbus_i     = 1'b0;
    perr_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic write to master 0, then read from master 2 with good parity.
    do_xfer(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_xfer(4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0);

    // Parity error: sticky holds until cleared; clear during a new error keeps it.
    do_xfer(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
    do_xfer(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_xfer(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    force_clr  = 1'b1;
    perr_clr_i = 1'b1;
    do_xfer(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    do_xfer(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    force_clr  = 1'b0;
    perr_clr_i = 1'b0;
    do_xfer(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Round robin with all masters requesting.
    for (int i = 0; i < 5; i++) do_xfer(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Request withdrawn mid-transfer; bus then stays idle.
    do_xfer(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
    do_xfer(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Randomised traffic with random clears.
    rand_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [NREQ-1:0] rq;
      rq = ($urandom_range(0, 7) == 0) ? '0 : NREQ'($urandom);
      do_xfer(rq, NREQ'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    rand_clr   = 1'b0;
    perr_clr_i = 1'b0;

    // Asynchronous reset in the middle of DRIVE.
    req_i = 4'b0001;
    rd_i  = 4'b0000;
    tick(1'b0);
    tick(1'b0);
    chk("drive_before_rst.be_", 32'(be_n_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    sticky_m = 1'b0;
    chk_all("async_rst", '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ptr_m = NREQ - 1;
    // Pointer back at NREQ-1: master 0 must win with everyone requesting.
    do_xfer(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_xfer(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
